// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit holding the HI/LO pair.
//   Clk   - rising-edge clock
//   Rst   - asynchronous active-high reset
//   A     - operand 1 / dividend / mthi-mtlo source
//   B     - operand 2 / divisor
//   Op    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   Start - operation request, sampled on the rising edge
//   Busy  - high while a multiply/divide iterates (32 cycles)
//   Done  - one-cycle pulse when HI/LO take a multiply/divide result
//   Hi/Lo - architectural HI/LO registers
module mult_div_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [31:0] opa_q, opa_d;     // original A, returned as HI on divide by zero
  logic        is_div_q, is_div_d;
  logic        qneg_q, qneg_d;   // product sign (mult) or quotient sign (div)
  logic        rneg_q, rneg_d;   // remainder sign
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand conditioning for a newly accepted op
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // One iteration step of each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] iter_next;

  // Final result formatting
  logic [63:0] prod;
  logic [31:0] quo_s, rem_s;

  logic        last, accept;

  always_comb begin
    a_neg = ~Op[0] & A[31];
    b_neg = ~Op[0] & B[31];
    a_mag = a_neg ? (32'd0 - A) : A;
    b_mag = b_neg ? (32'd0 - B) : B;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring step: shift in next dividend bit; when the trial subtract
    // fails the shifted remainder is below the divisor and fits in 32 bits.
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_rem  = div_ge ? 32'(div_sh - {1'b0, opb_q}) : div_sh[31:0];
    div_next = {div_rem, acc_q[30:0], div_ge};

    iter_next = is_div_q ? div_next : mul_next;

    prod  = qneg_q ? (64'd0 - iter_next) : iter_next;
    quo_s = qneg_q ? (32'd0 - iter_next[31:0]) : iter_next[31:0];
    rem_s = rneg_q ? (32'd0 - iter_next[63:32]) : iter_next[63:32];

    last   = (state_q == S_RUN) && (cnt_q == 5'd31);
    accept = Start && !Op[2] && ((state_q == S_IDLE) || last);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    opa_d    = opa_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && (Op == OP_MTHI)) hi_d = A;
        if (Start && (Op == OP_MTLO)) lo_d = A;
      end
      S_RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (opb_q == 32'd0) begin
            hi_d = opa_q;
            lo_d = '1;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The completing edge may also launch the next op (back-to-back issue)
    if (accept) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      acc_d    = {32'd0, a_mag};
      opb_d    = b_mag;
      opa_d    = A;
      is_div_d = Op[1];
      qneg_d   = a_neg ^ b_neg;
      rneg_d   = a_neg;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      opa_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      opa_q    <= opa_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
